// File: rtl/qu_common.sv
// Shared types for the Qu retire path: uop classes,
// memory-queue entries and per-channel retire slots.
package qu_common;

    localparam int NUM_RETIRE_CH     = 2;
    localparam int PHY_RF_ADDR_WIDTH = 6;
    localparam int ROB_ADDR_WIDTH    = 5;

    typedef logic [31:0]                  phy_rf_data_t;
    typedef logic [31:0]                  pc_t;
    typedef logic [ROB_ADDR_WIDTH-1:0]    rob_addr_t;
    typedef logic [PHY_RF_ADDR_WIDTH-1:0] phy_rf_addr_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_BEQ = 4'd5,
        OP_BNE = 4'd6,
        OP_BLT = 4'd7,
        OP_LW  = 4'd8,
        OP_SW  = 4'd9
    } op_t;

    typedef enum logic [2:0] {
        UC_NOP,
        UC_ALU,
        UC_BRANCH,
        UC_LOAD,
        UC_STORE
    } uop_class_t;

    typedef struct packed {
        op_t          op;
        phy_rf_data_t vj;
        phy_rf_data_t vk;
        phy_rf_data_t a;
        phy_rf_addr_t dest;
        rob_addr_t    rob_addr;
    } res_st_cell_t;

    typedef struct packed {
        uop_class_t   cls;
        logic [31:0]  addr;
        logic [31:0]  data;
        phy_rf_addr_t dest;
        rob_addr_t    rob_addr;
    } mem_q_entry_t;

    typedef struct packed {
        logic         wr;
        logic         ret;
        phy_rf_addr_t dest;
        phy_rf_data_t data;
        rob_addr_t    rob;
        logic         mp;
        pc_t          tgt;
    } ret_slot_t;

    function automatic uop_class_t uop_class(op_t op);
        uop_class_t c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: c = UC_ALU;
            OP_BEQ, OP_BNE, OP_BLT:        c = UC_BRANCH;
            OP_LW:                         c = UC_LOAD;
            OP_SW:                         c = UC_STORE;
            default:                       c = UC_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_op_queue.sv
// Memory-op FIFO: up to NUM_CH in-order pushes per cycle,
// one pop, head and occupancy exposed to the issue FSM.
module mem_op_queue
    import qu_common::*;
#(
    parameter  int NUM_CH = NUM_RETIRE_CH,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         push_en,
    input  mem_q_entry_t [NUM_CH-1:0] push_data,
    input  logic                      pop,
    output logic [CW-1:0]             count,
    output mem_q_entry_t              head
);

    mem_q_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wa [NUM_CH];
    logic [CW-1:0]  npush;

    // Enabled channels are packed densely, lowest channel first.
    always_comb begin
        npush = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wa[i] = wr_ptr + npush[AW-1:0];
            npush = npush + CW'(push_en[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push_en[i]) mem[wa[i]] <= push_data[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + npush[AW-1:0];
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + npush - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/retire_nway.sv
// N-channel retire/writeback stage: single-cycle ALU and
// branch retire, serialised loads/stores, branch redirect.
module retire_nway
    import qu_common::*;
#(
    parameter int NUM_CH   = NUM_RETIRE_CH,
    parameter int MQ_DEPTH = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [NUM_CH-1:0]                         op_valid_in,
    input  res_st_cell_t [NUM_CH-1:0]                 op_in,
    input  phy_rf_data_t [NUM_CH-1:0]                 value_in,
    input  logic [NUM_CH-1:0]                         comp_result_in,
    output logic                                      op_ready_out,
    output logic [NUM_CH-1:0]                         phy_rf_wr_en,
    output logic [NUM_CH-1:0][PHY_RF_ADDR_WIDTH-1:0]  phy_rf_wr_addr,
    output phy_rf_data_t [NUM_CH-1:0]                 phy_rf_wr_data,
    output logic [NUM_CH-1:0]                         busy_table_wr_en,
    output logic [NUM_CH-1:0][PHY_RF_ADDR_WIDTH-1:0]  busy_table_wr_addr,
    output logic [NUM_CH-1:0]                         busy_table_wr_data,
    output logic [NUM_CH-1:0]                         retire_en,
    output rob_addr_t [NUM_CH-1:0]                    retire_rob_addr,
    output phy_rf_data_t [NUM_CH-1:0]                 retire_value,
    output logic                                      mispredicted_branch,
    output pc_t                                       pc_to_jump,
    output logic                                      dmem_wr_en_out,
    output logic                                      dmem_rd_en_out,
    output logic [31:0]                               dmem_addr_out,
    output logic [31:0]                               dmem_data_out,
    input  logic                                      dmem_valid_in,
    input  logic [31:0]                               dmem_data_in
);

    localparam int CW = $clog2(MQ_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } mstate_t;

    mstate_t                   state;
    mstate_t                   state_nx;
    uop_class_t                cls [NUM_CH];
    logic [NUM_CH-1:0]         live;
    logic [NUM_CH-1:0]         push_en;
    mem_q_entry_t [NUM_CH-1:0] push_data;
    ret_slot_t                 nxt [NUM_CH];
    ret_slot_t                 slot_q [NUM_CH];
    ret_slot_t                 skid_q;
    ret_slot_t                 mem_ret;
    logic                      skid_v;
    logic                      ready_q;
    logic                      mem_done;
    logic [CW-1:0]             count;
    logic [CW:0]               free;
    mem_q_entry_t              head;
    logic                      unused_vk;

    // A pop this cycle frees a slot for the incoming bundle.
    assign free = (CW+1)'(MQ_DEPTH) - (CW+1)'(count)
                + (CW+1)'(mem_done);
    assign op_ready_out = ready_q && !skid_v
                       && free >= (CW+1)'(NUM_CH);

    always_comb begin : accept
        logic found;
        found     = 1'b0;
        unused_vk = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cls[i]       = uop_class(op_in[i].op);
            unused_vk    = unused_vk ^ (^op_in[i].vk);
            live[i]      = op_ready_out && op_valid_in[i]
                        && cls[i] != UC_NOP && !found;
            nxt[i]       = '0;
            push_en[i]   = 1'b0;
            push_data[i] = '{
                cls:      cls[i],
                addr:     op_in[i].vj + op_in[i].a,
                data:     value_in[i],
                dest:     op_in[i].dest,
                rob_addr: op_in[i].rob_addr
            };
            if (live[i]) begin
                unique case (1'b1)
                    cls[i] == UC_ALU: begin
                        nxt[i].wr   = 1'b1;
                        nxt[i].ret  = 1'b1;
                        nxt[i].dest = op_in[i].dest;
                        nxt[i].data = value_in[i];
                        nxt[i].rob  = op_in[i].rob_addr;
                    end
                    cls[i] == UC_BRANCH: begin
                        nxt[i].ret = 1'b1;
                        nxt[i].rob = op_in[i].rob_addr;
                        nxt[i].mp  = comp_result_in[i];
                        nxt[i].tgt = op_in[i].a;
                        found      = comp_result_in[i];
                    end
                    default: push_en[i] = 1'b1;
                endcase
            end
        end
    end

    mem_op_queue #(
        .NUM_CH (NUM_CH),
        .DEPTH  (MQ_DEPTH)
    ) u_mq (
        .clk       (clk),
        .rst       (rst),
        .push_en   (push_en),
        .push_data (push_data),
        .pop       (mem_done),
        .count     (count),
        .head      (head)
    );

    always_comb begin
        state_nx       = state;
        mem_done       = 1'b0;
        dmem_rd_en_out = 1'b0;
        dmem_wr_en_out = 1'b0;
        dmem_addr_out  = '0;
        dmem_data_out  = '0;
        unique case (state)
            S_IDLE: if (count != '0) state_nx = S_REQ;
            S_REQ: begin
                dmem_rd_en_out = head.cls == UC_LOAD;
                dmem_wr_en_out = head.cls == UC_STORE;
                dmem_addr_out  = head.addr;
                dmem_data_out  = head.data;
                state_nx       = S_WAIT;
            end
            S_WAIT: begin
                if (dmem_valid_in) begin
                    mem_done = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_ret      = '0;
        mem_ret.ret  = 1'b1;
        mem_ret.wr   = head.cls == UC_LOAD;
        mem_ret.dest = head.dest;
        mem_ret.rob  = head.rob_addr;
        if (head.cls == UC_LOAD) mem_ret.data = dmem_data_in;
    end

    // Memory retire owns channel 0; a colliding result waits in skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ready_q <= 1'b0;
            skid_v  <= 1'b0;
            skid_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= 1'b1;
            for (int i = 1; i < NUM_CH; i++) slot_q[i] <= nxt[i];
            if (mem_done) begin
                slot_q[0] <= mem_ret;
                if (nxt[0].ret) begin
                    skid_q <= nxt[0];
                    skid_v <= 1'b1;
                end
            end else if (skid_v) begin
                slot_q[0] <= skid_q;
                skid_v    <= 1'b0;
            end else begin
                slot_q[0] <= nxt[0];
            end
        end
    end

    always_comb begin
        mispredicted_branch = 1'b0;
        pc_to_jump          = '0;
        busy_table_wr_data  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            phy_rf_wr_en[i]       = slot_q[i].wr;
            phy_rf_wr_addr[i]     = slot_q[i].dest;
            phy_rf_wr_data[i]     = slot_q[i].data;
            busy_table_wr_en[i]   = slot_q[i].wr;
            busy_table_wr_addr[i] = slot_q[i].dest;
            retire_en[i]          = slot_q[i].ret;
            retire_rob_addr[i]    = slot_q[i].rob;
            retire_value[i]       = slot_q[i].data;
            if (slot_q[i].mp) begin
                mispredicted_branch = 1'b1;
                pc_to_jump          = slot_q[i].tgt;
            end
        end
    end

endmodule
